// File: rtl/div_if.sv
// Handshake and data bundle between the execute stage and the divider.
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    // execute stage side
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Operands are latched as magnitudes; signs are reapplied on the final edge,
// giving truncating (round-toward-zero) MIPS semantics.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    div_if.slave   div
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     rem_q;      // partial remainder
    logic [DATA_W-1:0]     dq_q;       // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]     dvs_q;      // divisor magnitude
    logic                  sgn_q;
    logic                  neg1_q;
    logic                  neg2_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;

    logic [DATA_W-1:0]     abs1, abs2;
    logic [DATA_W:0]       pr;
    logic                  ge;
    logic [DATA_W-1:0]     diff;
    logic [DATA_W-1:0]     rem_d, dq_d;
    logic [DATA_W-1:0]     quo_fix, rem_fix;

    // operand magnitudes (raw operands in unsigned mode)
    always_comb begin
        abs1 = (div.signed_div_i && div.opdata1_i[DATA_W-1]) ? -div.opdata1_i : div.opdata1_i;
        abs2 = (div.signed_div_i && div.opdata2_i[DATA_W-1]) ? -div.opdata2_i : div.opdata2_i;
    end

    // one restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        pr    = {rem_q, dq_q[DATA_W-1]};
        ge    = (pr >= {1'b0, dvs_q});
        // when ge holds the true difference is below the divisor, so the
        // low DATA_W bits of the subtraction are exact
        diff  = pr[DATA_W-1:0] - dvs_q;
        rem_d = ge ? diff : pr[DATA_W-1:0];
        dq_d  = {dq_q[DATA_W-2:0], ge};
    end

    // sign correction applied when the result is loaded
    always_comb begin
        quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -dq_q : dq_q;
        rem_fix = (sgn_q && neg1_q) ? -rem_q : rem_q;
    end

    // control FSM with registered result and ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (div.start_i && !div.annul_i) begin
                        sgn_q  <= div.signed_div_i;
                        neg1_q <= div.opdata1_i[DATA_W-1];
                        neg2_q <= div.opdata2_i[DATA_W-1];
                        dq_q   <= abs1;
                        dvs_q  <= abs2;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        state_q <= (div.opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= END;
                end
                ON: begin
                    if (div.annul_i) begin
                        state_q <= FREE;
                        ready_q <= 1'b0;
                    end else if (cnt_q != CNT_END) begin
                        rem_q <= rem_d;
                        dq_q  <= dq_d;
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                END: begin
                    if (!div.start_i || div.annul_i) begin
                        state_q  <= FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign div.result_o = result_q;
    assign div.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed test of div_unit: driver pushes expected results into a queue,
// an independent monitor pops and compares on each rising ready_o.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] exp_q[$];
    logic rdy_prev = 1'b0;

    div_if #(.DATA_W(32)) dif();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .div (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // monitor: compare every result as it is presented
    initial begin
        forever begin
            @(negedge clk);
            if (dif.ready_o && !rdy_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready actual=%h required=none", dif.result_o);
                end else begin
                    chk("result", dif.result_o, exp_q.pop_front());
                end
            end
            rdy_prev = dif.ready_o;
        end
    end

    // called at a negedge; issues one division, checks latency, hold and drop
    task automatic run_div(input string nm, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n = 0;
        bit got = 0;
        dif.signed_div_i = s;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        exp_q.push_back(exp);
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // operands must already be latched
                dif.signed_div_i = ~s;
                dif.opdata1_i    = 32'hDEAD_BEEF;
                dif.opdata2_i    = 32'h0000_0000;
            end
            if (dif.ready_o) got = 1;
        end
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        repeat (2) begin
            @(negedge clk);
            chk({nm, "_hold_ready"}, {63'b0, dif.ready_o}, 64'd1);
            chk({nm, "_hold_result"}, dif.result_o, exp);
        end
        dif.start_i = 1'b0;
        @(negedge clk);
        chk({nm, "_drop_ready"}, {63'b0, dif.ready_o}, 64'd0);
        chk({nm, "_drop_result"}, dif.result_o, 64'd0);
    endtask

    initial begin
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'b0, dif.ready_o}, 64'd0);
        chk("reset_result", dif.result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("u100_7",   1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34);
        run_div("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
        run_div("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        run_div("s-100_-7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34);
        run_div("u5_9",     1'b0, 32'd5,          32'd9,        64'h00000005_00000000, 34);
        run_div("umax_max", 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 34);
        run_div("u_by0",    1'b0, 32'h12345678,   32'd0,        64'h0, 2);
        run_div("s_by0",    1'b1, 32'h12345678,   32'd0,        64'h0, 2);
        run_div("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 34);
        run_div("u_ovf",    1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 34);

        // annul after ten iterations of ON, then restart on the next cycle
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd1000;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        repeat (11) @(negedge clk);
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        @(negedge clk);
        chk("annul_ready", {63'b0, dif.ready_o}, 64'd0);
        dif.annul_i = 1'b0;
        run_div("u_after_annul", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);

        // synchronous reset in the middle of a division
        dif.signed_div_i = 1'b1;
        dif.opdata1_i    = 32'd1000;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        dif.start_i = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {63'b0, dif.ready_o}, 64'd0);
        chk("midrst_result", dif.result_o, 64'd0);
        rst = 1'b0;
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

        repeat (40) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
